// File: rtl/dice_game_ctrl_if.sv
// Signal bundle between the dice game controller and its button/ack sources and display consumers.
// master drives the debounced button and ack; slave is the controller that produces every result.
interface dice_game_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             rb;
    logic             ack;
    logic [3:0]       die1;
    logic [3:0]       die2;
    logic [4:0]       sum;
    logic [4:0]       point;
    logic [2:0]       state;
    logic             roll;
    logic             win;
    logic             lose;
    logic [7:0]       rolls_used;
    logic [CNT_W-1:0] wins;
    logic [CNT_W-1:0] losses;

    modport master (
        output rb, ack,
        input  die1, die2, sum, point, state, roll, win, lose, rolls_used, wins, losses
    );

    modport slave (
        input  rb, ack,
        output die1, die2, sum, point, state, roll, win, lose, rolls_used, wins, losses
    );
endinterface

// File: rtl/dice_game_ctrl.sv
// Two-die game controller: dice spin while rb is held, first-roll and point-phase rules scaled to SIDES,
// optional roll limit, and saturating win/loss tallies.
module dice_game_ctrl #(
    parameter int SIDES     = 6,
    parameter int MAX_ROLLS = 8,
    parameter int CNT_W     = 8
) (
    input  logic            clk,
    input  logic            rst,
    dice_game_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ROLL1 = 3'd1;
    localparam logic [2:0] S_EVAL1 = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_ROLLN = 3'd4;
    localparam logic [2:0] S_EVALN = 3'd5;
    localparam logic [2:0] S_WIN   = 3'd6;
    localparam logic [2:0] S_LOSE  = 3'd7;

    localparam logic [3:0]       FACE_MAX  = 4'(SIDES);
    localparam logic [4:0]       LOSE_LOW  = 5'd2;
    localparam logic [4:0]       LOSE_MID  = 5'(SIDES + 2);
    localparam logic [4:0]       LOSE_HIGH = 5'(2 * SIDES - 1);
    localparam logic [7:0]       ROLL_LIM  = 8'(MAX_ROLLS);
    localparam logic [CNT_W-1:0] TALLY_MAX = '1;
    localparam logic [CNT_W-1:0] TALLY_ONE = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [3:0]       die1_q, die2_q;
    logic [4:0]       point_q, point_d;
    logic [7:0]       rolls_q, rolls_d;
    logic [CNT_W-1:0] wins_q, losses_q;
    logic             roll_q, win_q, lose_q;

    logic [4:0] sum;
    logic [7:0] rolls_inc;
    logic       sum_mod3;
    logic       first_lose;
    logic       limit_hit;
    logic       spin;
    logic       enter_win;
    logic       enter_lose;

    assign sum        = {1'b0, die1_q} + {1'b0, die2_q};
    assign rolls_inc  = rolls_q + 8'd1;
    assign sum_mod3   = (sum % 5'd3) == 5'd0;
    assign first_lose = (sum == LOSE_LOW) || (sum == LOSE_MID) || (sum == LOSE_HIGH);
    assign limit_hit  = (MAX_ROLLS != 0) && (rolls_inc == ROLL_LIM);

    // Next-state and per-game register updates; dice and tallies are handled in the register block.
    always_comb begin
        state_d = state_q;
        point_d = point_q;
        rolls_d = rolls_q;
        spin    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.rb) begin
                    state_d = S_ROLL1;
                    point_d = 5'd0;
                    rolls_d = 8'd0;
                end
            end
            S_ROLL1: begin
                if (bus.rb) spin = 1'b1;
                else        state_d = S_EVAL1;
            end
            S_EVAL1: begin
                if (sum_mod3) begin
                    state_d = S_WIN;
                end else if (first_lose) begin
                    state_d = S_LOSE;
                end else begin
                    point_d = sum;
                    state_d = S_POINT;
                end
            end
            S_POINT: begin
                if (bus.rb) state_d = S_ROLLN;
            end
            S_ROLLN: begin
                if (bus.rb) spin = 1'b1;
                else        state_d = S_EVALN;
            end
            S_EVALN: begin
                rolls_d = rolls_inc;
                if (sum_mod3)             state_d = S_LOSE;
                else if (sum == point_q)  state_d = S_WIN;
                else if (limit_hit)       state_d = S_LOSE;
                else                      state_d = S_POINT;
            end
            S_WIN, S_LOSE: begin
                if (bus.ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_win  = (state_d == S_WIN)  && (state_q != S_WIN);
    assign enter_lose = (state_d == S_LOSE) && (state_q != S_LOSE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            die1_q   <= 4'd1;
            die2_q   <= 4'd1;
            point_q  <= 5'd0;
            rolls_q  <= 8'd0;
            wins_q   <= '0;
            losses_q <= '0;
            roll_q   <= 1'b0;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            point_q <= point_d;
            rolls_q <= rolls_d;
            roll_q  <= (state_d == S_ROLL1) || (state_d == S_ROLLN);
            win_q   <= (state_d == S_WIN);
            lose_q  <= (state_d == S_LOSE);
            // die1 is the fast digit; die2 steps only when die1 wraps.
            if (spin) begin
                if (die1_q == FACE_MAX) begin
                    die1_q <= 4'd1;
                    die2_q <= (die2_q == FACE_MAX) ? 4'd1 : die2_q + 4'd1;
                end else begin
                    die1_q <= die1_q + 4'd1;
                end
            end
            if (enter_win && (wins_q != TALLY_MAX))
                wins_q <= wins_q + TALLY_ONE;
            if (enter_lose && (losses_q != TALLY_MAX))
                losses_q <= losses_q + TALLY_ONE;
        end
    end

    assign bus.die1       = die1_q;
    assign bus.die2       = die2_q;
    assign bus.sum        = sum;
    assign bus.point      = point_q;
    assign bus.state      = state_q;
    assign bus.roll       = roll_q;
    assign bus.win        = win_q;
    assign bus.lose       = lose_q;
    assign bus.rolls_used = rolls_q;
    assign bus.wins       = wins_q;
    assign bus.losses     = losses_q;
endmodule

// File: tb/tb_dice_game_ctrl.sv
// Randomized game sequences for dice_game_ctrl, checked against a position-based game model.
module tb_dice_game_ctrl;
    localparam int SIDES     = 6;
    localparam int MAX_ROLLS = 2;
    localparam int CNT_W     = 2;
    localparam int TMAX      = (1 << CNT_W) - 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dice_game_ctrl_if #(.CNT_W(CNT_W)) bus ();

    dice_game_ctrl #(
        .SIDES(SIDES), .MAX_ROLLS(MAX_ROLLS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: dice as a single position 0..SIDES^2-1, die1 the low digit.
    int m_pos, m_point, m_rolls, m_wins, m_losses, m_state;
    logic [2:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int d1_of(input int pos);
        return pos % SIDES + 1;
    endfunction

    function automatic int d2_of(input int pos);
        return pos / SIDES + 1;
    endfunction

    function automatic bit first_roll_wins(input int pos);
        return ((d1_of(pos) + d2_of(pos)) % 3) == 0;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_point = 0; m_rolls = 0; m_wins = 0; m_losses = 0; m_state = 0;
    endtask

    task automatic model_result(input bit won);
        if (won) begin
            m_state = 6;
            if (m_wins < TMAX) m_wins++;
        end else begin
            m_state = 7;
            if (m_losses < TMAX) m_losses++;
        end
    endtask

    task automatic model_roll(input int k);
        int s;
        m_pos = (m_pos + k) % (SIDES * SIDES);
        s = d1_of(m_pos) + d2_of(m_pos);
        if (m_state == 0) begin
            if (s % 3 == 0)                                      model_result(1'b1);
            else if (s == 2 || s == SIDES + 2 || s == 2*SIDES-1) model_result(1'b0);
            else begin m_point = s; m_state = 3; end
        end else begin
            m_rolls++;
            if (s % 3 == 0)                                     model_result(1'b0);
            else if (s == m_point)                              model_result(1'b1);
            else if (MAX_ROLLS != 0 && m_rolls == MAX_ROLLS)    model_result(1'b0);
            else m_state = 3;
        end
        exp_q.push_back(3'(m_state));
    endtask

    task automatic check_all(input string tag);
        logic [2:0] exp_state;
        exp_state = 3'(m_state);
        if (exp_q.size() > 0) exp_state = exp_q.pop_front();
        check({tag, ".state"},  bus.state, exp_state);
        check({tag, ".die1"},   bus.die1, d1_of(m_pos));
        check({tag, ".die2"},   bus.die2, d2_of(m_pos));
        check({tag, ".sum"},    bus.sum, d1_of(m_pos) + d2_of(m_pos));
        check({tag, ".point"},  bus.point, m_point);
        check({tag, ".rolls"},  bus.rolls_used, m_rolls);
        check({tag, ".wins"},   bus.wins, m_wins);
        check({tag, ".losses"}, bus.losses, m_losses);
        check({tag, ".roll"},   bus.roll, 0);
        check({tag, ".win"},    bus.win, m_state == 6);
        check({tag, ".lose"},   bus.lose, m_state == 7);
    endtask

    // driver tasks
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus.rb = 1'b0; bus.ack = 1'b0;
        @(negedge clk);
        model_reset();
        check_all("reset");
        rst = 1'b0;
    endtask

    task automatic do_roll(input int k, input string tag);
        int from;
        from = m_state;
        @(negedge clk);
        bus.rb = 1'b1; bus.ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (from == 0) begin m_point = 0; m_rolls = 0; end
        check({tag, ".roll_state"}, bus.state, (from == 0) ? 1 : 4);
        check({tag, ".roll_out"}, bus.roll, 1);
        for (int i = 0; i < k; i++) begin
            bus.ack = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.rb = 1'b0; bus.ack = 1'b0;
        @(negedge clk);
        check({tag, ".eval"}, bus.state, (from == 0) ? 2 : 5);
        @(negedge clk);
        model_roll(k);
        check_all(tag);
    endtask

    task automatic do_ack(input string tag);
        int held;
        held = m_state;
        @(negedge clk);
        bus.rb = 1'b1; bus.ack = 1'b0;
        @(negedge clk);
        check({tag, ".hold"}, bus.state, held);
        bus.ack = 1'b1; bus.rb = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.ack = 1'b0; bus.rb = 1'b0;
        m_state = 0;
        check_all(tag);
    endtask

    initial begin
        int k;
        rst = 1'b1; bus.rb = 1'b0; bus.ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        // directed games
        do_reset();
        do_roll(1, "k1_win");
        check("k1_win.die1_const", bus.die1, 2);
        check("k1_win.state_const", bus.state, 6);
        do_ack("k1_ack");

        do_reset();
        do_roll(0, "k0_lose");
        check("k0_lose.state_const", bus.state, 7);

        do_reset();
        do_roll(3, "pt5");
        check("pt5.point_const", bus.point, 5);
        do_roll(6, "pt5_k6_lose");
        check("pt5_k6.rolls_const", bus.rolls_used, 1);

        do_reset();
        do_roll(3, "pt5b");
        do_roll(36, "pt5_k36_win");
        check("pt5_k36.state_const", bus.state, 6);

        do_reset();
        do_roll(3, "pt5c");
        do_roll(2, "lim_1");
        check("lim_1.state_const", bus.state, 3);
        do_roll(2, "lim_2");
        check("lim_2.state_const", bus.state, 7);
        check("lim_2.rolls_const", bus.rolls_used, 2);

        // tally saturation: four first-roll wins
        do_reset();
        for (int g = 0; g < 4; g++) begin
            k = 0;
            while (!first_roll_wins((m_pos + k) % (SIDES * SIDES))) k++;
            do_roll(k, "sat_win");
            do_ack("sat_ack");
        end
        check("sat.wins_const", bus.wins, 3);

        // random games
        do_reset();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 60) == 0)      do_reset();
            else if (m_state == 6 || m_state == 7) do_ack("rnd_ack");
            else                                  do_roll($urandom_range(0, 40), "rnd_roll");
        end

        // reset during ROLLN
        for (int i = 0; i < 40 && m_state != 3; i++) begin
            if (m_state == 6 || m_state == 7) do_ack("pre_ack");
            else                              do_roll($urandom_range(0, 40), "pre_roll");
        end
        check("pre_rst.point_state", bus.state, 3);
        @(negedge clk);
        bus.rb = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_rst.rolln", bus.state, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.rb = 1'b0;
        model_reset();
        check_all("mid_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dice_game_ctrl.md
# dice_game_ctrl

Parametrised two-die game controller, successor to the fixed 6-sided dual-dice FSM. It generates both dice internally by spinning counters while the roll button is held, and applies the rule set scaled to SIDES. It holds a fixed point across rolls, forces a loss after a configurable roll limit, and keeps saturating win/loss tallies. It sits between the debounced button/ack inputs and the display/LED logic.

## Interface
- SIDES, 6: faces per die; legal range 2..15.
- MAX_ROLLS, 8: limit on point-phase rolls before a forced loss; 0 = unlimited; legal range 0..255.
- CNT_W, 8: width of the wins/losses tallies.

- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high; overrides every other input.
- rb  in  1  roll button, debounced synchronous level.
- ack  in  1  acknowledges a WIN/LOSE result and returns to IDLE.
- die1, die2  out  4  current die faces, 1..SIDES.
- sum  out  5  die1+die2, combinational from the die registers.
- point  out  5  latched point; 0 when no point is set.
- state  out  3  FSM state code.
- roll  out  1  high while state is ROLL1 or ROLLN.
- win, lose  out  1  high while state is WIN or LOSE respectively.
- rolls_used  out  8  number of point-phase rolls evaluated in the current game.
- wins, losses  out  CNT_W  saturating tallies of games won and lost.

## Operation
State codes:
- IDLE=0, ROLL1=1, EVAL1=2, POINT=3, ROLLN=4, EVALN=5, WIN=6, LOSE=7.

Reset (rst=1 at a clock edge) loads:
- state=IDLE, die1=die2=1, point=0, rolls_used=0, wins=losses=0.
- Result: roll=win=lose=0, sum=2.

Transitions:
- IDLE: rb=1 → ROLL1; on the same edge, point and rolls_used clear to 0.
- ROLL1: rb=1 → stay and advance dice; rb=0 → EVAL1, dice frozen.
- EVAL1, first-roll rules, evaluated in priority order:
  - sum%3==0 → WIN.
  - sum==2, sum==SIDES+2 or sum==2*SIDES-1 → LOSE.
  - otherwise point←sum → POINT.
- POINT: rb=1 → ROLLN.
- ROLLN: same as ROLL1, but rb=0 → EVALN.
- EVALN, point-phase rules:
  - rolls_used increments.
  - sum%3==0 → LOSE.
  - sum==point → WIN.
  - MAX_ROLLS≠0 and the incremented rolls_used==MAX_ROLLS → LOSE.
  - otherwise → POINT; point does not change.
- WIN / LOSE: ack=1 → IDLE; rb is ignored in these states.

Dice advance, each cycle with state∈{ROLL1, ROLLN} and rb=1:
- die1 increments.
- die1==SIDES wraps die1 to 1 and increments die2.
- die2==SIDES wraps die2 to 1.
- Dice are never reloaded except by rst; they carry over between rolls and games.

Tallies:
- wins increments on the edge that enters WIN; losses increments on the edge that enters LOSE.
- Both saturate at 2^CNT_W−1.

Arithmetic:
- Max sum is 30 (5 bits).
- The %3 test is exact over 0..31.
- With SIDES=6 the lose set is {2, 8, 11}.

## Timing
- All outputs are registered except sum, which derives combinationally from the registered dice.
- Spin count k = number of cycles in a ROLL state with rb=1; an rb pulse lasting only the IDLE/POINT cycle gives k=0.
- Result latency: rb falling while in ROLL → EVAL on the next edge → WIN/LOSE/POINT one edge later. win/lose, tallies and point all become visible on that same edge.
- ack and rb both high in WIN/LOSE → IDLE. A new game needs rb=1 sampled in IDLE.
- rst mid-roll or mid-game: back to IDLE next edge, everything cleared including tallies.
- ack outside WIN/LOSE: ignored.

## Test plan
- SIDES=6, reset, rb high 2 cycles (k=1) → dice 2/1, sum=3, WIN 2 edges after rb falls, wins=1; then ack → IDLE.
- From reset, rb high 1 cycle (k=0) → sum=2 → LOSE, losses=1, point=0.
- From reset, k=3 → dice 4/1, point=5, state=POINT. Then k=6 → dice 4/2, sum=6 → LOSE, rolls_used=1.
- Point 5 at dice 4/1, then k=36 (one full dice cycle) → dice 4/1, sum=5 → WIN, rolls_used=1.
- MAX_ROLLS=2, point 5 at dice 4/1:
  - k=2 → 6/1, sum=7 → POINT, rolls_used=1.
  - k=2 → 2/2, sum=4 → LOSE by roll limit, rolls_used=2.
- CNT_W=2: four wins in a row → wins stays 3. rst asserted during ROLLN → IDLE, dice 1/1, tallies 0.
